// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Synthesizable ALU initiator for bring-up and BIST. Commands (a, b, op) are
// queued in a small FIFO and issued one at a time to the ALU over a
// valid/ready request channel. The sequencer then waits a bounded number of
// cycles for the response, strobes the captured result downstream for one
// cycle, and folds it into a rotate-xor signature.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          command push handshake (cmd_ready = !full)
//   cmd_a, cmd_b, cmd_op         command payload
//   alu_req_valid/alu_req_ready  request handshake towards the ALU
//   alu_a, alu_b, alu_op         operands/opcode presented to the ALU
//   alu_rsp_valid, alu_rsp_c     ALU response
//   res_valid, res_c             one-cycle result strobe and held result
//   sig                          running result signature
//   issued_cnt                   completed-command count (wraps at 16 bits)
//   timeout_err, stray_err       sticky error flags, cleared only by rst
module alu_op_sequencer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_op,
  output logic             alu_req_valid,
  input  logic             alu_req_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic             alu_rsp_valid,
  input  logic [WIDTH-1:0] alu_rsp_c,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_c,
  output logic [WIDTH-1:0] sig,
  output logic [15:0]      issued_cnt,
  output logic             timeout_err,
  output logic             stray_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int EW = 2 * WIDTH + 4;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Rotate left by one and fold in the new result.
  function automatic logic [WIDTH-1:0] sig_next(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] c);
    return {cur[WIDTH-2:0], cur[WIDTH-1]} ^ c;
  endfunction

  state_t            state_r, state_n;
  logic [CW-1:0]     cnt_r;
  logic [EW-1:0]     mem_r [DEPTH];
  logic [AW:0]       wr_ptr_r, rd_ptr_r;
  logic              full_s, empty_s, push_s, pop_s;
  logic              capture_s, timeout_s, stray_s;
  logic [EW-1:0]     head_s;
  logic              alu_req_valid_r, res_valid_r, timeout_err_r, stray_err_r;
  logic [WIDTH-1:0]  alu_a_r, alu_b_r, res_c_r, sig_r;
  logic [3:0]        alu_op_r;
  logic [15:0]       issued_cnt_r;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  // Held low during reset so every output reads 0 while rst is asserted.
  assign cmd_ready = !full_s && !rst;
  assign push_s    = cmd_valid && cmd_ready;
  assign head_s    = mem_r[rd_ptr_r[AW-1:0]];

  // Next-state and per-cycle event decode.
  always_comb begin
    state_n   = state_r;
    pop_s     = 1'b0;
    capture_s = 1'b0;
    timeout_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s   = 1'b1;
          state_n = ST_ISSUE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (alu_req_ready) begin
          state_n = ST_WAIT;
        end else begin
          state_n = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // A response on the last allowed cycle still wins over the timeout.
        if (alu_rsp_valid) begin
          capture_s = 1'b1;
          state_n   = ST_DONE;
        end else if (cnt_r == CNT_LAST) begin
          timeout_s = 1'b1;
          state_n   = ST_IDLE;
        end else begin
          state_n = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    stray_s = alu_rsp_valid && (state_r != ST_WAIT);
  end

  // Command FIFO storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // FSM state and WAIT-cycle counter (zero on every entry to WAIT).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_n;
      if (state_r == ST_WAIT) begin
        cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= {CW{1'b0}};
      end
    end
  end

  // Request channel: operands load on pop and are held afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_req_valid_r <= 1'b0;
      alu_a_r         <= {WIDTH{1'b0}};
      alu_b_r         <= {WIDTH{1'b0}};
      alu_op_r        <= 4'd0;
    end else begin
      alu_req_valid_r <= (state_n == ST_ISSUE);
      if (pop_s) begin
        {alu_op_r, alu_a_r, alu_b_r} <= head_s;
      end
    end
  end

  // Result strobe, signature, count and sticky flags; all become visible
  // together in the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_r   <= 1'b0;
      res_c_r       <= {WIDTH{1'b0}};
      sig_r         <= {WIDTH{1'b0}};
      issued_cnt_r  <= 16'd0;
      timeout_err_r <= 1'b0;
      stray_err_r   <= 1'b0;
    end else begin
      res_valid_r <= capture_s;
      if (capture_s) begin
        res_c_r      <= alu_rsp_c;
        sig_r        <= sig_next(sig_r, alu_rsp_c);
        issued_cnt_r <= issued_cnt_r + 16'd1;
      end
      timeout_err_r <= timeout_err_r | timeout_s;
      stray_err_r   <= stray_err_r | stray_s;
    end
  end

  assign alu_req_valid = alu_req_valid_r;
  assign alu_a         = alu_a_r;
  assign alu_b         = alu_b_r;
  assign alu_op        = alu_op_r;
  assign res_valid     = res_valid_r;
  assign res_c         = res_c_r;
  assign sig           = sig_r;
  assign issued_cnt    = issued_cnt_r;
  assign timeout_err   = timeout_err_r;
  assign stray_err     = stray_err_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed testbench for alu_op_sequencer with a behavioural ALU responder
// and a result scoreboard (expected results queued at command time).
module tb_alu_op_sequencer;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [W-1:0]  cmd_a, cmd_b;
  logic [3:0]    cmd_op;
  logic          alu_req_valid, alu_req_ready;
  logic [W-1:0]  alu_a, alu_b;
  logic [3:0]    alu_op;
  logic          alu_rsp_valid;
  logic [W-1:0]  alu_rsp_c;
  logic          res_valid;
  logic [W-1:0]  res_c, sig;
  logic [15:0]   issued_cnt;
  logic          timeout_err, stray_err;

  int            checks = 0;
  int            errors = 0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  sig_m;
  logic [15:0]   cnt_m;

  // ALU responder model controls: rsp_delay < 0 means never respond.
  int            rsp_delay;
  logic          stray_inj;
  logic          mdl_valid, pend;
  logic [W-1:0]  mdl_c, pend_c;
  int            left;

  assign alu_rsp_valid = mdl_valid | stray_inj;
  assign alu_rsp_c     = mdl_c;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(W), .DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_req_valid(alu_req_valid), .alu_req_ready(alu_req_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_rsp_valid(alu_rsp_valid), .alu_rsp_c(alu_rsp_c),
    .res_valid(res_valid), .res_c(res_c), .sig(sig),
    .issued_cnt(issued_cnt), .timeout_err(timeout_err), .stray_err(stray_err)
  );

  function automatic logic [W-1:0] alu_calc(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  // Behavioural ALU: answers rsp_delay cycles after the request handshake.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_valid <= 1'b0;
      mdl_c     <= '0;
      pend      <= 1'b0;
      pend_c    <= '0;
      left      <= 0;
    end else begin
      mdl_valid <= 1'b0;
      if (alu_req_valid && alu_req_ready && rsp_delay >= 0) begin
        if (rsp_delay == 0) begin
          mdl_valid <= 1'b1;
          mdl_c     <= alu_calc(alu_a, alu_b, alu_op);
        end else begin
          pend   <= 1'b1;
          left   <= rsp_delay - 1;
          pend_c <= alu_calc(alu_a, alu_b, alu_op);
        end
      end else if (pend) begin
        if (left == 0) begin
          mdl_valid <= 1'b1;
          mdl_c     <= pend_c;
          pend      <= 1'b0;
        end else begin
          left <= left - 1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    chk("cmd_accept", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic expect_result();
    logic [W-1:0] e;
    for (int i = 0; i < 60 && !res_valid; i++) tick();
    chk("res_seen", res_valid, 1);
    if (res_valid) begin
      chk("sb_nonempty", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e     = exp_q.pop_front();
        sig_m = {sig_m[W-2:0], sig_m[W-1]} ^ e;
        cnt_m = cnt_m + 16'd1;
        chk("res_c", res_c, e);
        chk("sig", sig, sig_m);
        chk("issued_cnt", issued_cnt, cnt_m);
      end
      tick();
      chk("res_strobe_one_cycle", res_valid, 0);
    end
  endtask

  initial begin
    int n, waited, seen;
    logic acc;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = 4'd0;
    alu_req_ready = 1'b1;
    rsp_delay = 0;
    stray_inj = 1'b0;
    sig_m = '0;
    cnt_m = 16'd0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    tick();

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_req_valid", alu_req_valid, 0);
    chk("rst_sig", sig, 0);
    chk("rst_issued", issued_cnt, 0);
    chk("rst_errs", {timeout_err, stray_err}, 0);

    // Single command, immediate ready and response
    exp_q.push_back(alu_calc(32'd5, 32'd3, 4'd0));
    send(32'd5, 32'd3, 4'd0);
    chk("req_valid_early", alu_req_valid, 0);
    tick();
    chk("req_valid_2cyc", alu_req_valid, 1);
    chk("alu_a", alu_a, 32'd5);
    chk("alu_b", alu_b, 32'd3);
    chk("alu_op", alu_op, 4'd0);
    expect_result();

    // Fill FIFO while the ALU stalls: 4 queued plus 1 in ISSUE
    alu_req_ready = 1'b0;
    n = 0;
    cmd_a = 32'd1; cmd_b = '0; cmd_op = 4'd0;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      acc = cmd_ready;
      tick();
      if (acc) begin
        n++;
        exp_q.push_back(W'(n));
        cmd_a = W'(n + 1);
      end
    end
    cmd_valid = 1'b0;
    chk("accepts_when_stalled", W'(n), 32'd5);
    chk("cmd_ready_full", cmd_ready, 0);
    chk("issue_held_valid", alu_req_valid, 1);
    chk("issue_held_a", alu_a, 32'd1);
    alu_req_ready = 1'b1;
    repeat (5) expect_result();

    // Timeout on the first command, second command still completes
    rsp_delay = -1;
    exp_q.push_back(alu_calc(32'd9, 32'd1, 4'd0));
    send(32'd7, 32'd0, 4'd0);
    send(32'd9, 32'd1, 4'd0);
    chk("to_issue_a", alu_a, 32'd7);
    tick();
    rsp_delay = 0;
    waited = 0;
    seen = 0;
    for (int i = 0; i < 40 && !timeout_err; i++) begin
      if (res_valid) seen++;
      tick();
      waited++;
    end
    chk("timeout_err", timeout_err, 1);
    chk("timeout_cycles", W'(waited), 32'd15);
    chk("timeout_no_res", W'(seen), 32'd0);
    expect_result();

    // Stray response while idle
    chk("stray_before", stray_err, 0);
    stray_inj = 1'b1;
    tick();
    stray_inj = 1'b0;
    chk("stray_err", stray_err, 1);
    chk("stray_sig", sig, sig_m);
    chk("stray_issued", issued_cnt, cnt_m);
    chk("stray_no_res", res_valid, 0);

    // Reset while in WAIT with 3 commands queued
    rsp_delay = -1;
    alu_req_ready = 1'b0;
    send(32'd11, 32'd0, 4'd0);
    send(32'd12, 32'd0, 4'd0);
    send(32'd13, 32'd0, 4'd0);
    send(32'd14, 32'd0, 4'd0);
    alu_req_ready = 1'b1;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_cmd_ready", cmd_ready, 0);
    chk("arst_req", {alu_req_valid, res_valid}, 0);
    chk("arst_alu_a", alu_a, 0);
    chk("arst_res_c", res_c, 0);
    chk("arst_sig", sig, 0);
    chk("arst_issued", issued_cnt, 0);
    chk("arst_errs", {timeout_err, stray_err}, 0);
    rsp_delay = 0;
    sig_m = '0;
    cnt_m = 16'd0;
    #1 rst = 1'b0;
    #1;
    chk("post_rst_ready", cmd_ready, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (res_valid || alu_req_valid) seen++;
    end
    chk("post_rst_quiet", W'(seen), 32'd0);

    // Response on the last allowed WAIT cycle counts as success
    rsp_delay = 14;
    exp_q.push_back(alu_calc(32'd20, 32'd22, 4'd1));
    send(32'd20, 32'd22, 4'd1);
    expect_result();
    chk("edge_no_timeout", timeout_err, 0);
    chk("edge_no_stray", stray_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
